// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU interrupt interface.
// irr is high while any byte is pending; each ack pops one byte; drops set a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     update,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     ack,
  input  logic                     ovf_clr,
  output logic                     irr,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  // Handshake decode; a full FIFO still accepts a byte when a pop frees a slot.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    full_s  = (count_r == CNT_FULL);
    pop_s   = ack && !empty_s;
    push_s  = update && (!full_s || pop_s);
    drop_s  = update && full_s && !pop_s;
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Outputs are decoded only from registered state, so irr cannot glitch.
  always_comb begin
    irr      = !empty_s;
    full     = full_s;
    count    = count_r;
    overflow = overflow_r;
    if (empty_s) begin
      data_out = {WIDTH{1'b0}};
    end else begin
      data_out = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference model is compared on every
// falling edge, plus literal expectations for the documented scenarios.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             update;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic             ovf_clr;
  logic             irr;
  logic [WIDTH-1:0] data_out;
  logic [4:0]       count;
  logic             full;
  logic             overflow;

  int vectors;
  int miscompares;
  bit cmp_en;

  logic [7:0] mq[$];
  bit         m_ovf;
  logic [7:0] dut_pop[$];
  logic [7:0] pushed[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .update(update), .data_in(data_in), .ack(ack),
    .ovf_clr(ovf_clr), .irr(irr), .data_out(data_out), .count(count),
    .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the reference model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("model_count", 32'(count), 32'(mq.size()));
        chk("model_irr", 32'(irr), 32'(mq.size() != 0));
        chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        chk("model_data_out", 32'(data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      end
    end
  end

  task automatic step(input logic u, input logic [7:0] d, input logic a, input logic c);
    bit was_full;
    bit do_pop;
    @(negedge clk);
    update = u; data_in = d; ack = a; ovf_clr = c;
    if (a && irr) dut_pop.push_back(data_out);
    @(posedge clk);
    if (reset) begin
      was_full = (mq.size() == DEPTH);
      do_pop   = a && (mq.size() != 0);
      if (u && was_full && !do_pop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (u && (!was_full || do_pop)) mq.push_back(d);
    end
    #1;
    update = 1'b0; ack = 1'b0; ovf_clr = 1'b0; data_in = 8'h00;
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && irr; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 chk("drain_empty", 32'(irr), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cmp_en = 1'b0; m_ovf = 1'b0;
    reset = 1'b0; update = 1'b0; data_in = 8'h00; ack = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_irr", 32'(irr), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Basic push then pop.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_irr", 32'(irr), 32'd1);
    chk("t1_head", 32'(data_out), 32'h41);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop1", 32'(data_out), 32'h42);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop2", 32'(data_out), 32'h43);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop3", 32'(data_out), 32'h00);
    chk("t1_irr_low", 32'(irr), 32'd0);

    // Fill, overflow, clear, and set-wins-over-clear.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_full", 32'(full), 32'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_head", 32'(data_out), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("t2_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr2", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_head", 32'(data_out), 32'h01);
    dut_pop.delete();
    drain(20);
    chk("t3_npop", 32'(dut_pop.size()), 32'd16);
    if (dut_pop.size() == 16) begin
      chk("t3_first", 32'(dut_pop[0]), 32'h01);
      chk("t3_last", 32'(dut_pop[15]), 32'hAA);
    end

    // Empty: lone ack, then update together with ack.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_data0", 32'(data_out), 32'h00);
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    chk("t5_count1", 32'(count), 32'd1);
    chk("t5_head", 32'(data_out), 32'h7E);
    chk("t5_irr", 32'(irr), 32'd1);
    drain(4);

    // Wrap: pushes every cycle with a varying pop pattern.
    dut_pop.delete();
    pushed.delete();
    for (int i = 0; i < 40; i++) begin
      pushed.push_back(8'(8'h80 + i));
      step(1'b1, 8'(8'h80 + i), (i % 3) != 0, 1'b0);
      if ((i % 8) == 7) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    drain(40);
    chk("t4_npop", 32'(dut_pop.size()), 32'd40);
    for (int i = 0; i < 40 && i < dut_pop.size(); i++)
      chk("t4_order", 32'(dut_pop[i]), 32'(pushed[i]));

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_irr", 32'(irr), 32'd0);
    chk("t6_data", 32'(data_out), 32'h00);
    chk("t6_ovf", 32'(overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("t6_after", 32'(data_out), 32'h3C);
    drain(4);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Buffers bytes from the UART receiver so that back-to-back characters are not lost while the CPU is busy.
- Sits between the receiver's update/data outputs and the CPU's irr/ack/uart_r_data interrupt interface, replacing the single-level interrupt latch.
- Raises irr while any byte is pending and pops one byte per ack.
- Reports overrun through a sticky flag.

Parameters:
- DEPTH, 16: number of byte entries. Must be a power of two, 2 or more.
- WIDTH, 8: data width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- update  input  1  one-cycle strobe from the receiver: a byte is valid on data_in.
- data_in  input  WIDTH  received byte, sampled when update=1.
- ack  input  1  CPU pop request; each cycle with ack=1 consumes one entry.
- ovf_clr  input  1  clears the sticky overflow flag.
- irr  output  1  interrupt request; high while the FIFO is non-empty.
- data_out  output  WIDTH  head entry (first-word fall-through); 0 when empty.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Therefore irr=0, full=0, data_out=0.
  - Memory contents are not reset.
  - Asserting reset mid-operation discards all entries immediately.
  - After reset deasserts, nothing happens until the next rising edge with reset=1.
- Storage and pointers:
  - Storage is a DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Derived signals:
  - empty = (count==0).
  - irr = !empty, derived only from registered count, so it is glitch-free.
  - full = (count==DEPTH).
  - data_out = empty ? 0 : mem[rd_ptr], combinational from registered state.
- Pop:
  - pop = ack && !empty.
  - On pop, rd_ptr increments.
  - ack while empty is ignored: no state change and no error.
- Push:
  - push = update && (!full || pop).
  - On push, mem[wr_ptr] <= data_in and wr_ptr increments.
  - A full FIFO with a simultaneous pop accepts the new byte.
- Count:
  - count <= count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
- Overflow:
  - update && full && !pop sets overflow <= 1 and the byte is dropped.
  - The FIFO is left unchanged.
- Overflow clear:
  - ovf_clr=1 clears overflow.
  - If a drop occurs in the same cycle, set wins and overflow stays 1.
- Empty with simultaneous update and ack:
  - The ack is ignored and the push proceeds.
  - Next cycle: count=1, irr=1, data_out=data_in.
- Latency:
  - A byte pushed at edge N is visible on data_out and irr is high after edge N (one-cycle latency from the update strobe).
  - A pop at edge N shows the next entry, or 0, after edge N.
- Handshake rule:
  - The CPU must drive ack as a single-cycle pulse per consumed byte.
  - Holding ack for k cycles pops up to k bytes.
- FIFO order is strictly preserved across pointer wrap-around.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles. Required: count=3, irr=1, data_out=0x41. Three ack pulses then yield data_out 0x42, 0x43, then 0; irr=0 after the third pop.
- Push 16 bytes 0x00..0x0F into the default DEPTH=16. Required: full=1. A 17th update with 0x55 gives overflow=1, count=16, and data_out still 0x00. Pulse ovf_clr: overflow=0.
- With the FIFO full, assert update(0xAA) and ack in the same cycle. Required: count stays 16, overflow stays 0, data_out becomes 0x01, and 0xAA is popped last.
- Wrap test: run 40 push/pop pairs with a varying fill level, using an incrementing byte pattern. Required: the popped sequence equals the pushed sequence, with no loss and no duplication.
- Empty FIFO, ack alone. Required: no change, count=0. Then update(0x7E) together with ack in one cycle. Required: count=1, data_out=0x7E.
- Push 5 bytes, then assert reset low asynchronously between clock edges. Required: count=0, irr=0, data_out=0, overflow=0 immediately, before the next clock edge.
